// File: rtl/lane_flow_ctrl.sv
// Game-flow sequencer for the 4-lane falling-block datapath: start/countdown/run/pause/over
// sequencing, stage-dependent scroll strobe, spawn scheduling and miss accounting.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | after reset, waiting for start
// COUNTDOWN | CD_TICKS periods of P0 before play begins
// RUN       | scroll strobes issued, spawns scheduled, misses counted
// PAUSE     | every counter frozen, waiting for the next pause pulse
// OVER      | MAX_MISS reached, waiting for start to restart
module lane_flow_ctrl #(
   parameter int P0        = 500,
   parameter int P1        = 250,
   parameter int P2        = 200,
   parameter int P3        = 150,
   parameter int P4        = 100,
   parameter int T1        = 10,
   parameter int T2        = 25,
   parameter int T3        = 40,
   parameter int T4        = 55,
   parameter int SPAWN_GAP = 5,
   parameter int MAX_MISS  = 3,
   parameter int CD_TICKS  = 3
) (
   input  logic       system_clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       miss,
   output logic       clear_field,
   output logic       scroll_tick,
   output logic       spawn_en,
   output logic [2:0] stage,
   output logic [7:0] scroll_count,
   output logic [1:0] miss_count,
   output logic [1:0] countdown,
   output logic [2:0] state,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_RUN       = 3'd2,
      S_PAUSE     = 3'd3,
      S_OVER      = 3'd4
   } state_t;

   localparam logic [15:0] P0_LAST    = 16'(P0 - 1);
   localparam logic [15:0] P1_LAST    = 16'(P1 - 1);
   localparam logic [15:0] P2_LAST    = 16'(P2 - 1);
   localparam logic [15:0] P3_LAST    = 16'(P3 - 1);
   localparam logic [15:0] P4_LAST    = 16'(P4 - 1);
   localparam logic [7:0]  T1_V       = 8'(T1);
   localparam logic [7:0]  T2_V       = 8'(T2);
   localparam logic [7:0]  T3_V       = 8'(T3);
   localparam logic [7:0]  T4_V       = 8'(T4);
   localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_GAP - 1);
   localparam logic [1:0]  MAX_MISS_V = 2'(MAX_MISS);
   localparam logic [1:0]  CD_V       = 2'(CD_TICKS);

   state_t      state_q, state_d;
   logic [15:0] period_q, period_d, period_last;
   logic [7:0]  spawn_q, spawn_d;
   logic [2:0]  stage_d;
   logic [7:0]  scroll_d, scroll_inc;
   logic [1:0]  miss_d, miss_inc, countdown_d;
   logic        clear_d, tick_d, spawn_en_d;
   logic        advance, miss_final;

   always_comb begin
      case (stage)
         3'd0:    period_last = P0_LAST;
         3'd1:    period_last = P1_LAST;
         3'd2:    period_last = P2_LAST;
         3'd3:    period_last = P3_LAST;
         default: period_last = P4_LAST;
      endcase
   end

   assign scroll_inc = (scroll_count == 8'hFF) ? 8'hFF : scroll_count + 8'd1;
   assign miss_inc   = miss_count + 2'd1;
   assign miss_final = miss && (miss_inc == MAX_MISS_V);

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      spawn_d     = spawn_q;
      stage_d     = stage;
      scroll_d    = scroll_count;
      miss_d      = miss_count;
      countdown_d = countdown;
      clear_d     = 1'b0;
      tick_d      = 1'b0;
      spawn_en_d  = 1'b0;
      advance     = 1'b0;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d     = S_COUNTDOWN;
               clear_d     = 1'b1;
               stage_d     = 3'd0;
               scroll_d    = 8'd0;
               miss_d      = 2'd0;
               period_d    = 16'd0;
               spawn_d     = 8'd0;
               countdown_d = CD_V;
            end
         end
         S_COUNTDOWN: begin
            if (period_q == P0_LAST) begin
               period_d    = 16'd0;
               countdown_d = (countdown == 2'd0) ? 2'd0 : countdown - 2'd1;
               if (countdown <= 2'd1)
                  state_d = S_RUN;
            end else begin
               period_d = period_q + 16'd1;
            end
         end
         S_RUN: begin
            if (miss)
               miss_d = miss_inc;
            // Leaving RUN freezes the period counter, so the strobe that would
            // have fired here is issued on the resume cycle instead.
            if (miss_final)
               state_d = S_OVER;
            else if (pause)
               state_d = S_PAUSE;
            else
               advance = 1'b1;
         end
         S_PAUSE: begin
            if (pause) begin
               state_d = S_RUN;
               advance = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (period_q == period_last) begin
            period_d   = 16'd0;
            tick_d     = 1'b1;
            scroll_d   = scroll_inc;
            spawn_en_d = (spawn_q == 8'd0);
            spawn_d    = (spawn_q >= SPAWN_LAST) ? 8'd0 : spawn_q + 8'd1;
            if (scroll_inc != scroll_count) begin
               if (scroll_inc == T1_V)      stage_d = 3'd1;
               else if (scroll_inc == T2_V) stage_d = 3'd2;
               else if (scroll_inc == T3_V) stage_d = 3'd3;
               else if (scroll_inc == T4_V) stage_d = 3'd4;
            end
         end else begin
            period_d = period_q + 16'd1;
         end
      end
   end

   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         period_q     <= 16'd0;
         spawn_q      <= 8'd0;
         stage        <= 3'd0;
         scroll_count <= 8'd0;
         miss_count   <= 2'd0;
         countdown    <= 2'd0;
         clear_field  <= 1'b0;
         scroll_tick  <= 1'b0;
         spawn_en     <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         spawn_q      <= spawn_d;
         stage        <= stage_d;
         scroll_count <= scroll_d;
         miss_count   <= miss_d;
         countdown    <= countdown_d;
         clear_field  <= clear_d;
         scroll_tick  <= tick_d;
         spawn_en     <= spawn_en_d;
         game_over    <= (state_d == S_OVER);
      end
   end

   assign state = state_q;

endmodule

// File: doc/lane_flow_ctrl.md
Name: lane_flow_ctrl

Overview:
- Game-flow sequencer for the 4-lane falling-block display datapath.
- Owns start/countdown/run/pause/game-over sequencing.
- Generates the scroll strobe with a stage-dependent period and schedules block spawns.
- Counts misses reported by the datapath. The datapath shifts and spawns only when strobed by this block.

Parameters:
- P0, default 500: scroll period (system_clk cycles) in stage 0
- P1, default 250: scroll period in stage 1
- P2, default 200: scroll period in stage 2
- P3, default 150: scroll period in stage 3
- P4, default 100: scroll period in stage 4
- T1, default 10: scroll count at which stage becomes 1
- T2, default 25: scroll count at which stage becomes 2
- T3, default 40: scroll count at which stage becomes 3
- T4, default 55: scroll count at which stage becomes 4
- SPAWN_GAP, default 5: scroll ticks between spawns
- MAX_MISS, default 3: misses that end the game
- CD_TICKS, default 3: countdown length in P0-periods

Ports:
- system_clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, start/restart request
- pause  in  1  one-cycle pulse, toggles RUN/PAUSE
- miss  in  1  one-cycle pulse from datapath: unhit block left bottom row
- clear_field  out  1  one-cycle pulse: datapath clears all lanes
- scroll_tick  out  1  one-cycle strobe: datapath shifts all lanes one row
- spawn_en  out  1  one-cycle strobe, only coincident with scroll_tick: datapath inserts a block at top row
- stage  out  3  current speed stage, 0..4
- scroll_count  out  8  scroll ticks since game start, saturates at 255
- miss_count  out  2  misses this game
- countdown  out  2  remaining countdown periods, valid in COUNTDOWN
- state  out  3  IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, OVER=4
- game_over  out  1  high while state==OVER

Behaviour:
Reset:
- state=IDLE.
- All outputs 0, all internal counters 0. Overrides every input in the same cycle.

IDLE / OVER:
- Counters hold. start -> COUNTDOWN next cycle, and clear_field=1 in that transition cycle.
- On the same transition, zero stage, scroll_count, miss_count, period counter and spawn counter; load countdown=CD_TICKS.
- pause and miss are ignored.

COUNTDOWN:
- 16-bit period counter counts 0..P0-1.
- On wrap: countdown decrements.
- When countdown reaches 0 on a wrap: -> RUN, period counter=0.
- No scroll_tick or spawn_en in this state. pause and miss are ignored.
- start is ignored.

RUN:
- Period counter counts 0..Pstage-1, where Pstage is selected by stage.
- At count==Pstage-1: scroll_tick=1 that cycle, and the counter returns to 0.
- On each scroll_tick:
  - scroll_count increments, saturating.
  - If the new scroll_count equals T1/T2/T3/T4, stage becomes 1/2/3/4. The new period applies from the next count cycle.
  - Spawn counter runs 0..SPAWN_GAP-1; spawn_en=1 when it is 0 before the increment. The first scroll in RUN therefore spawns.
- miss pulse: miss_count increments. If the new value equals MAX_MISS -> OVER next cycle, and no further strobes are issued.
- pause pulse -> PAUSE. All counters freeze at their current values.
- start is ignored.

PAUSE:
- All counters frozen, no strobes.
- pause pulse -> RUN; the period counter resumes from its frozen value.
- miss and start are ignored.

Simultaneous events:
- miss and scroll_tick in the same cycle: both are processed.
- miss reaching MAX_MISS together with pause: OVER wins.
- scroll_tick is never asserted in the cycle RUN is exited.
- stage saturates at 4. scroll_count saturates at 255 and stage logic then holds.

Outputs:
- All outputs are registered.
- Strobes are exactly one system_clk wide.

Test Plan:
- Reset then start at cycle 10:
  - clear_field one cycle.
  - state=1 with countdown 3, 2, 1 each 500 cycles apart.
  - state=2 after 1500 cycles.
  - First scroll_tick with spawn_en 500 cycles later.
- RUN with defaults:
  - spawn_en on scroll ticks 1, 6, 11, ...
  - stage becomes 1 at tick 10; tick-to-tick spacing changes from 500 to 250 cycles.
  - stage becomes 4 at tick 55 with spacing 100.
- pause at period count 123:
  - No strobes for 1000 cycles.
  - After the second pause, the next scroll_tick arrives exactly Pstage-124 cycles after resume.
- Three miss pulses in RUN, the third coincident with pause:
  - miss_count 1, 2, 3.
  - state=4, game_over=1, no further scroll_tick.
  - Subsequent pause and miss are ignored.
- From OVER, start:
  - clear_field pulse.
  - stage, scroll_count and miss_count all 0; state=1.
- rst asserted mid-RUN in the same cycle as a scroll_tick would occur:
  - Next cycle all outputs 0, state=0, no strobe.
